// File: rtl/sort_pkg.sv
// Shared constants for the byte sorter datapath: byte width and FSM state encoding.
package sort_pkg;

  localparam int unsigned BYTE_W = 8;

  // Encoding 2'd3 is unused and decodes as ST_LOAD.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

endpackage

// File: rtl/comparator_8.sv
// Unsigned 8-bit magnitude comparator producing mutually exclusive less/equal/greater flags.
module comparator_8
  import sort_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              lt,
  output logic              eq,
  output logic              gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/sort_engine_8.sv
// Bubble-sort engine: loads DEPTH bytes serially, sorts in place with one compare-and-swap
// per cycle, then streams the block out smallest-first.
module sort_engine_8
  import sort_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [CW-1:0] LastIdx  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LastPass = CW'(DEPTH - 2);

  logic [1:0]        state_q, state_d, st;
  logic [CW-1:0]     wr_idx_q, wr_idx_d;
  logic [CW-1:0]     pass_q, pass_d;
  logic [CW-1:0]     j_q, j_d, j_nxt;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic              swapped_q, swapped_d;
  logic              done_q, done_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];

  logic cmp_lt, cmp_eq, cmp_gt;
  logic unused_cmp;

  assign j_nxt = j_q + 1'b1;

  comparator_8 u_cmp (
    .a  (mem_q[j_q]),
    .b  (mem_q[j_nxt]),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // Only gt steers the swap; lt/eq stay visible for debug.
  assign unused_cmp = cmp_lt ^ cmp_eq;

  assign st = (state_q == ST_SORT || state_q == ST_OUT) ? state_q : ST_LOAD;

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    pass_d    = pass_q;
    j_d       = j_q;
    rd_idx_d  = rd_idx_q;
    swapped_d = swapped_q;
    done_d    = 1'b0;
    mem_d     = mem_q;

    case (st)
      ST_SORT: begin
        if (cmp_gt) begin
          mem_d[j_q]   = mem_q[j_nxt];
          mem_d[j_nxt] = mem_q[j_q];
          swapped_d    = 1'b1;
        end
        if (j_q == LastPass - pass_q) begin
          // A pass with no swap means the block is already ordered.
          if (!(swapped_q || cmp_gt) || pass_q == LastPass) begin
            state_d  = ST_OUT;
            rd_idx_d = '0;
            done_d   = 1'b1;
          end else begin
            pass_d    = pass_q + 1'b1;
            j_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          j_d = j_nxt;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (rd_idx_q == LastIdx) begin
            state_d  = ST_LOAD;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        if (in_valid) begin
          mem_d[wr_idx_q] = in_data;
          if (wr_idx_q == LastIdx) begin
            wr_idx_d  = '0;
            pass_d    = '0;
            j_d       = '0;
            swapped_d = 1'b0;
            state_d   = ST_SORT;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_idx_q  <= '0;
      pass_q    <= '0;
      j_q       <= '0;
      rd_idx_q  <= '0;
      swapped_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      pass_q    <= pass_d;
      j_q       <= j_d;
      rd_idx_q  <= rd_idx_d;
      swapped_q <= swapped_d;
      done_q    <= done_d;
    end
  end

  // Storage contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_ready  = (st == ST_LOAD);
  assign out_valid = (st == ST_OUT);
  assign busy      = (st == ST_SORT);
  assign done      = done_q;
  assign out_data  = (st == ST_OUT) ? mem_q[rd_idx_q] : '0;

endmodule

// File: tb/tb_sort_engine_8.sv
// Self-checking bench for sort_engine_8: directed and random blocks against a queue-sort model.
module tb_sort_engine_8;

  typedef logic [7:0] blk_t [8];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  sort_engine_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Swap count of a stable bubble sort equals the number of strict inversions.
  function automatic int inversions(input blk_t v);
    int n = 0;
    for (int i = 0; i < 8; i++)
      for (int k = i + 1; k < 8; k++)
        if (v[i] > v[k]) n++;
    return n;
  endfunction

  // Compare count: full passes of shrinking length, stopping after the first clean pass.
  function automatic int sort_cycles(input blk_t v);
    int a [8];
    int cyc = 0;
    int t;
    bit sw;
    for (int i = 0; i < 8; i++) a[i] = int'(v[i]);
    for (int p = 0; p < 7; p++) begin
      sw = 1'b0;
      for (int i = 0; i < 7 - p; i++) begin
        cyc++;
        if (a[i] > a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    return cyc;
  endfunction

  task automatic run_block(input blk_t v, input bit bp, input bit noise, output int busy_cnt);
    int q[$];
    int done_cnt = 0;
    int sw_cnt = 0;
    int k = 0;
    int cyc;
    logic [3:0] pat = 4'b1001;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) q.push_back(int'(v[i]));
    q.sort();

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("load_in_ready[%0d]", i), in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[i];
    end
    @(negedge clk);
    in_valid = noise;
    in_data  = 8'hAA;

    for (cyc = 0; cyc < 200; cyc++) begin
      if (done) done_cnt++;
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (busy && dut.cmp_gt) sw_cnt++;
      if (cyc == 0) check("sort_in_ready", in_ready, 0);
      @(negedge clk);
    end
    check("sort_finished", out_valid, 1);

    cyc = 0;
    while (k < 8 && cyc < 100) begin
      check("out_valid", out_valid, 1);
      check("out_in_ready", in_ready, 0);
      check($sformatf("out_data[%0d]", k), out_data, q[k]);
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      if (out_ready) k++;
      cyc++;
      @(negedge clk);
      if (done) done_cnt++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_count", k, 8);
    check("end_in_ready", in_ready, 1);
    check("end_out_valid", out_valid, 0);
    check("sort_cycles", busy_cnt, sort_cycles(v));
    check("swap_count", sw_cnt, inversions(v));
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin
    blk_t v;
    int   bc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_block(v, 1'b0, 1'b0, bc);
    check("reverse_busy_28", bc, 28);

    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    run_block(v, 1'b0, 1'b0, bc);
    check("sorted_busy_7", bc, 7);

    v = '{8'd255, 8'd0, 8'd128, 8'd0, 8'd255, 8'd7, 8'd7, 8'd1};
    run_block(v, 1'b0, 1'b0, bc);

    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    run_block(v, 1'b1, 1'b0, bc);

    v = '{8'd9, 8'd200, 8'd3, 8'd3, 8'd77, 8'd0, 8'd150, 8'd42};
    run_block(v, 1'b0, 1'b1, bc);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, (r % 2 == 0) ? 255 : 7));
      run_block(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bc);
    end

    // Abort in the middle of a sort.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(8 - i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("midsort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_block(v, 1'b0, 1'b0, bc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
